dcache_line_mover: RTL and testbench
====================================

Name: dcache_line_mover

Overview:
Line-transfer engine that sits directly upstream of the data-cache way SRAM (512x32, byte-enabled simple dual-port, 1-cycle unregistered read latency).
- Refill: requests one cache line burst from external memory and writes each returned beat into the SRAM write port.
- Writeback: streams one cache line out of the SRAM read port to the memory write channel, with valid/ready backpressure and no bubbles.
- One command is handled at a time. A done pulse closes every command.

Parameters:
ADDR_WIDTH, 9, SRAM word address width
DATA_WIDTH, 32, SRAM/memory data width
BE_WIDTH, 4, SRAM byte-enable width (DATA_WIDTH/8)
LINE_WORDS, 8, words per line; power of 2, from 2 to 64
MEM_ADDR_WIDTH, 32, external byte address width
IDX_WIDTH, ADDR_WIDTH-log2(LINE_WORDS), line index width (derived localparam; 6 at defaults)

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_wb  in  1  1=writeback, 0=refill
cmd_index  in  IDX_WIDTH  SRAM line index
cmd_mem_addr  in  MEM_ADDR_WIDTH  line-aligned memory byte address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
mem_rreq_valid  out  1  line read request
mem_rreq_ready  in  1  request accepted
mem_rreq_addr  out  MEM_ADDR_WIDTH  latched cmd_mem_addr
mem_rdata_valid  in  1  read beat; no backpressure
mem_rdata  in  DATA_WIDTH  read beat data
mem_wvalid  out  1  write beat valid
mem_wready  in  1  write beat accepted
mem_waddr  out  MEM_ADDR_WIDTH  latched cmd_mem_addr, stable for whole line
mem_wdata  out  DATA_WIDTH  equals sram_rd_data
mem_wlast  out  1  high on final beat
sram_wr_en  out  1  SRAM write enable
sram_wr_addr  out  ADDR_WIDTH  {index, word_cnt}
sram_wr_data  out  DATA_WIDTH  registered mem_rdata
sram_wr_byte_en  out  BE_WIDTH  all ones whenever sram_wr_en=1, else 0
sram_rd_addr  out  ADDR_WIDTH  {index, rd_word_next} (combinational)
sram_rd_data  in  DATA_WIDTH  SRAM data, valid 1 cycle after its address

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; word counters, latched index and latched address all 0.
  - All outputs 0, except cmd_ready=1.
  - Reset mid-operation abandons the line. Partially written SRAM words remain. Beats already in flight are dropped.
- States: IDLE, RF_REQ, RF_DATA, WB_PRIME, WB_DATA, DONE.
- IDLE: when cmd_valid&cmd_ready, latch cmd_index and cmd_mem_addr, clear word_cnt. Next state is WB_PRIME if cmd_wb=1, else RF_REQ.
- RF_REQ: mem_rreq_valid=1 until mem_rreq_ready, then go to RF_DATA.
- RF_DATA: each mem_rdata_valid beat is registered.
  - Next cycle: sram_wr_en=1, sram_wr_addr={index,word_cnt}, sram_wr_data=beat; word_cnt then increments.
  - Latency from beat to SRAM write is exactly 1 cycle. Back-to-back beats give back-to-back writes.
  - After the write of word LINE_WORDS-1, go to DONE.
- mem_rdata_valid outside RF_DATA (including RF_REQ) is ignored.
- WB_PRIME: sram_rd_addr={index,0}; lasts one cycle, then go to WB_DATA.
- WB_DATA: mem_wvalid=1, mem_wdata=sram_rd_data, mem_wlast=(word_cnt==LINE_WORDS-1).
  - On mem_wvalid&mem_wready, word_cnt increments and sram_rd_addr shows word_cnt+1 in the same cycle. This sustains one beat per cycle.
  - While stalled, sram_rd_addr holds {index,word_cnt}, so mem_wdata stays stable.
  - The handshake with mem_wlast=1 goes to DONE.
- mem_wvalid, once asserted, is not withdrawn before its handshake, and mem_wdata/mem_wlast do not change while stalled.
- DONE: done=1 for one cycle, cmd_ready=0, then go to IDLE. Back-to-back commands therefore have at least 1 idle-accept cycle between done and the next command.
- word_cnt is log2(LINE_WORDS) bits and wraps to 0 after LINE_WORDS-1. sram addresses never leave the latched line.
- The engine never writes the SRAM during writeback and never reads it in a way that matters during refill.

Test Plan:
- Refill, index=3, addr=0x0000_1000, 8 beats 0xA0..0xA7 on consecutive cycles -> one rreq with addr 0x1000; sram writes to 24..31 with data A0..A7 and byte_en=0xF, each 1 cycle after its beat; done 1 cycle after the last write.
- Refill with gapped beats (valid on every other cycle), plus a stray beat during RF_REQ -> the stray beat produces no write; exactly 8 writes in order; word addresses unchanged.
- Writeback, index=63, SRAM preloaded with 0x100+i, mem_wready=1 -> beats 0x100..0x107 on consecutive cycles starting 1 cycle after WB_PRIME; mem_wlast only on 0x107; then done.
- Writeback with mem_wready low for 3 cycles at beat 4 -> mem_wdata holds 0x104 and mem_wvalid stays high; no beat skipped or duplicated.
- rst_n pulsed low during refill beat 5 -> outputs clear immediately; cmd_ready=1; a new refill command completes correctly.
- cmd_valid held high across two commands -> second command accepted only after done; cmd_ready=0 during busy.

Source files
------------

// File: rtl/dcache_line_mover_if.sv
// Bus bundle for the data-cache line mover.
// The master view belongs to the engine: it issues memory read requests,
// drives memory write beats and drives the way SRAM ports. The slave view is
// the surrounding environment (command source, memory and SRAM).
interface dcache_line_mover_if #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = 4,
    parameter int LINE_WORDS     = 8,
    parameter int MEM_ADDR_WIDTH = 32
);
    localparam int IDX_WIDTH = ADDR_WIDTH - $clog2(LINE_WORDS);

    // command channel
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_wb;
    logic [IDX_WIDTH-1:0]      cmd_index;
    logic [MEM_ADDR_WIDTH-1:0] cmd_mem_addr;
    logic                      busy;
    logic                      done;

    // memory read request and returned beats
    logic                      mem_rreq_valid;
    logic                      mem_rreq_ready;
    logic [MEM_ADDR_WIDTH-1:0] mem_rreq_addr;
    logic                      mem_rdata_valid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    // memory write channel
    logic                      mem_wvalid;
    logic                      mem_wready;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_wlast;

    // way SRAM ports
    logic                      sram_wr_en;
    logic [ADDR_WIDTH-1:0]     sram_wr_addr;
    logic [DATA_WIDTH-1:0]     sram_wr_data;
    logic [BE_WIDTH-1:0]       sram_wr_byte_en;
    logic [ADDR_WIDTH-1:0]     sram_rd_addr;
    logic [DATA_WIDTH-1:0]     sram_rd_data;

    modport master (
        input  cmd_valid, cmd_wb, cmd_index, cmd_mem_addr,
        output cmd_ready, busy, done,
        output mem_rreq_valid, mem_rreq_addr,
        input  mem_rreq_ready, mem_rdata_valid, mem_rdata,
        output mem_wvalid, mem_waddr, mem_wdata, mem_wlast,
        input  mem_wready,
        output sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en, sram_rd_addr,
        input  sram_rd_data
    );

    modport slave (
        output cmd_valid, cmd_wb, cmd_index, cmd_mem_addr,
        input  cmd_ready, busy, done,
        input  mem_rreq_valid, mem_rreq_addr,
        output mem_rreq_ready, mem_rdata_valid, mem_rdata,
        input  mem_wvalid, mem_waddr, mem_wdata, mem_wlast,
        output mem_wready,
        input  sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en, sram_rd_addr,
        output sram_rd_data
    );
endinterface

// File: rtl/dcache_line_mover.sv
// Line-transfer engine in front of the data-cache way SRAM.
// Refill: one burst read request, each returned beat written to the SRAM one
// cycle later. Writeback: the line is streamed from the SRAM read port to the
// memory write channel at one beat per cycle, holding steady under backpressure.
module dcache_line_mover #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = 4,
    parameter int LINE_WORDS     = 8,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    dcache_line_mover_if.master  bus
);
    localparam int CNT_WIDTH = $clog2(LINE_WORDS);
    localparam int IDX_WIDTH = ADDR_WIDTH - CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RF_REQ,
        RF_DATA,
        WB_PRIME,
        WB_DATA,
        DONE
    } state_t;

    state_t                    state_reg, state_next;
    logic [CNT_WIDTH-1:0]      word_cnt_reg, word_cnt_next;
    logic [IDX_WIDTH-1:0]      index_reg, index_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                      beat_valid_reg, beat_valid_next;
    logic [DATA_WIDTH-1:0]     beat_data_reg, beat_data_next;

    logic                      rf_write;
    logic                      rf_last_write;
    logic                      wb_fire;
    logic [CNT_WIDTH-1:0]      rd_word_next;

    // A registered beat is written the very next cycle; beats only get
    // registered in RF_DATA, so no extra state qualification is needed.
    assign rf_write      = beat_valid_reg;
    assign rf_last_write = rf_write && (word_cnt_reg == LAST_WORD);
    assign wb_fire       = (state_reg == WB_DATA) && bus.mem_wready;

    // Read address looks one word ahead on a handshake so the SRAM's
    // one-cycle latency never leaves a bubble; it holds while stalled.
    assign rd_word_next  = wb_fire ? (word_cnt_reg + CNT_WIDTH'(1)) : word_cnt_reg;

    // State and datapath registers; reset drops any line in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            word_cnt_reg   <= '0;
            index_reg      <= '0;
            addr_reg       <= '0;
            beat_valid_reg <= 1'b0;
            beat_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            word_cnt_reg   <= word_cnt_next;
            index_reg      <= index_next;
            addr_reg       <= addr_next;
            beat_valid_reg <= beat_valid_next;
            beat_data_reg  <= beat_data_next;
        end
    end

    // Next-state, command latching, word counting and beat capture.
    always_comb begin
        state_next      = state_reg;
        word_cnt_next   = word_cnt_reg;
        index_next      = index_reg;
        addr_next       = addr_reg;
        beat_valid_next = 1'b0;
        beat_data_next  = beat_data_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    index_next    = bus.cmd_index;
                    addr_next     = bus.cmd_mem_addr;
                    word_cnt_next = '0;
                    state_next    = bus.cmd_wb ? WB_PRIME : RF_REQ;
                end
            end
            RF_REQ: begin
                if (bus.mem_rreq_ready) begin
                    state_next = RF_DATA;
                end
            end
            RF_DATA: begin
                if (rf_write) begin
                    word_cnt_next = word_cnt_reg + CNT_WIDTH'(1);
                end
                if (rf_last_write) begin
                    state_next = DONE;
                end
                // A beat arriving alongside the final write would be past
                // the end of the line, so it is not captured.
                if (bus.mem_rdata_valid && !rf_last_write) begin
                    beat_valid_next = 1'b1;
                    beat_data_next  = bus.mem_rdata;
                end
            end
            WB_PRIME: begin
                state_next = WB_DATA;
            end
            WB_DATA: begin
                if (wb_fire) begin
                    word_cnt_next = word_cnt_reg + CNT_WIDTH'(1);
                    if (word_cnt_reg == LAST_WORD) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready      = (state_reg == IDLE);
    assign bus.busy           = (state_reg != IDLE);
    assign bus.done           = (state_reg == DONE);

    assign bus.mem_rreq_valid = (state_reg == RF_REQ);
    assign bus.mem_rreq_addr  = addr_reg;

    assign bus.mem_wvalid     = (state_reg == WB_DATA);
    assign bus.mem_waddr      = addr_reg;
    assign bus.mem_wdata      = (state_reg == WB_DATA) ? bus.sram_rd_data : '0;
    assign bus.mem_wlast      = (state_reg == WB_DATA) && (word_cnt_reg == LAST_WORD);

    assign bus.sram_wr_en     = rf_write;
    assign bus.sram_wr_addr   = {index_reg, word_cnt_reg};
    assign bus.sram_wr_data   = beat_data_reg;
    assign bus.sram_rd_addr   = {index_reg, rd_word_next};

    // Every lane is enabled on a line write: the engine only moves whole words.
    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_byte_en
            assign bus.sram_wr_byte_en[gi] = rf_write;
        end
    endgenerate

endmodule

// File: tb/tb_dcache_line_mover.sv
// Bench for dcache_line_mover: a vector table of refill/writeback commands
// plus hand-written sequences for reset-in-flight and held cmd_valid.
// Expected SRAM writes and memory write beats sit in scoreboard queues,
// each tagged with the cycle it must appear in.
module tb_dcache_line_mover;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LW  = 8;
    localparam int MAW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_line_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                           .LINE_WORDS(LW), .MEM_ADDR_WIDTH(MAW)) bus ();

    dcache_line_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                        .LINE_WORDS(LW), .MEM_ADDR_WIDTH(MAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SRAM model: byte-enabled write, one-cycle read latency, backdoor preload.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_en) sram[pre_addr] <= pre_data;
        else if (bus.sram_wr_en)
            for (int b = 0; b < BW; b++)
                if (bus.sram_wr_byte_en[b]) sram[bus.sram_wr_addr][b*8 +: 8] <= bus.sram_wr_data[b*8 +: 8];
        bus.sram_rd_data <= sram[bus.sram_rd_addr];
    end

    typedef struct {
        logic          wb;
        logic [5:0]    idx;
        logic [31:0]   addr;
        logic [31:0]   base;       // word k of the line carries base+k
        logic [AW-1:0] exp_word0;  // expected SRAM address of word 0
        int            gap;        // idle cycles between refill beats
        bit            stray;      // beat during RF_REQ
        int            rreq_delay;
        int            stall_beat;
        int            stall_len;
    } vec_t;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_exp_t;
    typedef struct { logic [DW-1:0] data; logic last; int cyc; } wb_exp_t;

    wr_exp_t wr_q[$];
    wb_exp_t wb_q[$];
    vec_t    vecs[6];
    vec_t    cur;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_done = 0;
    int n_rreq = 0;
    int n_accept = 0;
    int last_xfer_cyc = 0;
    int wb_start = 0;
    bit wb_active = 0;
    bit model_busy = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_wdata = '0;
    logic prev_wlast = 1'b0;
    logic [159:0] reset_out;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [159:0] out_vec();
        return {3'b0, bus.cmd_ready, bus.busy, bus.done, bus.mem_rreq_valid, bus.mem_rreq_addr,
                bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.mem_wlast, bus.sram_wr_en,
                bus.sram_wr_addr, bus.sram_wr_data, bus.sram_wr_byte_en, bus.sram_rd_addr};
    endfunction

    // Sampled on the falling edge: compares DUT activity with the scoreboard.
    task automatic monitor();
        wr_exp_t we;
        wb_exp_t be;
        if (!rst_n) begin
            model_busy = 0;
            wb_active  = 0;
            prev_stall = 0;
            return;
        end
        check("busy", bus.busy, model_busy);
        check("cmd_ready", bus.cmd_ready, !model_busy);
        if (prev_stall) begin
            check("stall_wvalid_held", bus.mem_wvalid, 1'b1);
            check("stall_wdata_held", bus.mem_wdata, prev_wdata);
            check("stall_wlast_held", bus.mem_wlast, prev_wlast);
        end
        prev_stall = bus.mem_wvalid && !bus.mem_wready;
        prev_wdata = bus.mem_wdata;
        prev_wlast = bus.mem_wlast;
        if (bus.mem_rreq_valid && bus.mem_rreq_ready) begin
            n_rreq++;
            check("rreq_addr", bus.mem_rreq_addr, cur.addr);
        end
        if (bus.sram_wr_en) begin
            if (wr_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sram_wr_unexpected: got write addr %0d data 0x%0h, required none", bus.sram_wr_addr, bus.sram_wr_data);
            end else begin
                we = wr_q.pop_front();
                check("sram_wr_addr", bus.sram_wr_addr, we.addr);
                check("sram_wr_data", bus.sram_wr_data, we.data);
                check("sram_wr_byte_en", bus.sram_wr_byte_en, 4'hF);
                check("sram_wr_cycle", cyc, we.cyc);
            end
            last_xfer_cyc = cyc;
        end else begin
            check("sram_byte_en_idle", bus.sram_wr_byte_en, 4'h0);
        end
        if (bus.mem_wvalid && bus.mem_wready) begin
            if (wb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wbeat_unexpected: got beat 0x%0h, required none", bus.mem_wdata);
            end else begin
                be = wb_q.pop_front();
                check("wbeat_data", bus.mem_wdata, be.data);
                check("wbeat_last", bus.mem_wlast, be.last);
                check("wbeat_cycle", cyc, be.cyc);
                check("wbeat_waddr", bus.mem_waddr, cur.addr);
            end
            last_xfer_cyc = cyc;
        end
        if (bus.done) begin
            n_done++;
            check("done_while_busy", model_busy, 1'b1);
            check("done_latency", cyc, last_xfer_cyc + 1);
            model_busy = 0;
            wb_active  = 0;
        end else if (bus.cmd_valid && !model_busy) begin
            n_accept++;
            model_busy = 1;
            if (bus.cmd_wb) begin
                wb_active = 1;
                wb_start  = cyc;
                for (int i = 0; i < LW; i++) begin
                    be.data = cur.base + 32'(i);
                    be.last = (i == LW - 1);
                    be.cyc  = cyc + 2 + i + ((i >= cur.stall_beat) ? cur.stall_len : 0);
                    wb_q.push_back(be);
                end
            end
        end
    endtask

    // One clock: sample on the falling edge, then drive just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        bus.mem_wready = !(wb_active && (cyc >= wb_start + 2 + cur.stall_beat)
                           && (cyc < wb_start + 2 + cur.stall_beat + cur.stall_len));
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (n_done == d0 && n < 80) begin
            cycle();
            n++;
        end
        check("done_seen", n_done - d0, 1);
    endtask

    task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int at);
        wr_exp_t e;
        e.addr = addr; e.data = data; e.cyc = at;
        wr_q.push_back(e);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int d0 = n_done;
        int r0 = n_rreq;
        cur = v;
        bus.cmd_wb = v.wb;
        bus.cmd_index = v.idx;
        bus.cmd_mem_addr = v.addr;
        bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
        if (!v.wb) begin
            for (int d = 0; d <= v.rreq_delay; d++) begin
                bus.mem_rreq_ready = (d == v.rreq_delay);
                if (v.stray && d == 0) begin
                    bus.mem_rdata_valid = 1'b1;
                    bus.mem_rdata = 32'hDEAD_BEEF;
                end
                cycle();
                bus.mem_rdata_valid = 1'b0;
            end
            bus.mem_rreq_ready = 1'b0;
            for (int k = 0; k < LW; k++) begin
                bus.mem_rdata_valid = 1'b1;
                bus.mem_rdata = v.base + 32'(k);
                push_wr(v.exp_word0 + AW'(k), v.base + 32'(k), cyc + 1);
                cycle();
                bus.mem_rdata_valid = 1'b0;
                if (k != LW - 1) repeat (v.gap) cycle();
            end
        end
        wait_done(d0);
        check("rreq_count", n_rreq - r0, (v.wb ? 0 : 1));
        check("wr_queue_drained", wr_q.size(), 0);
        check("wb_queue_drained", wb_q.size(), 0);
        $display("vec %0d: %s idx=%0d addr=0x%08h done at cycle %0d", id, v.wb ? "writeback" : "refill", v.idx, v.addr, cyc);
    endtask

    initial begin
        int d0, acc0, first_acc, second_acc;
        vec_t v;
        vecs[0] = '{1'b0, 6'd3,  32'h0000_1000, 32'h0000_00A0, 9'd24,  0, 1'b0, 0, 0, 0};
        vecs[1] = '{1'b0, 6'd10, 32'h0000_02A0, 32'h5500_0000, 9'd80,  1, 1'b1, 2, 0, 0};
        vecs[2] = '{1'b1, 6'd63, 32'h8000_0FE0, 32'h0000_0100, 9'd504, 0, 1'b0, 0, 0, 0};
        vecs[3] = '{1'b1, 6'd63, 32'h4000_0000, 32'h0000_0100, 9'd504, 0, 1'b0, 0, 4, 3};
        vecs[4] = '{1'b1, 6'd3,  32'h0000_1000, 32'h0000_00A0, 9'd24,  0, 1'b0, 0, 0, 1};
        vecs[5] = '{1'b1, 6'd10, 32'h0000_3000, 32'h5500_0000, 9'd80,  0, 1'b0, 0, 7, 2};
        cur = vecs[0];
        reset_out = 160'd1 << 156;

        bus.cmd_valid = 1'b0; bus.cmd_wb = 1'b0; bus.cmd_index = '0; bus.cmd_mem_addr = '0;
        bus.mem_rreq_ready = 1'b0; bus.mem_rdata_valid = 1'b0; bus.mem_rdata = '0;
        bus.mem_wready = 1'b1;

        // Preload line 63 with 0x100+i while the engine is held in reset.
        for (int i = 0; i < LW; i++) begin
            pre_en = 1'b1; pre_addr = AW'(504 + i); pre_data = 32'h100 + 32'(i);
            cycle();
        end
        pre_en = 1'b0;
        check("reset_outputs", out_vec(), reset_out);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("idle_outputs", out_vec(), reset_out);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset asserted while refill beat 5 is on the bus.
        v = '{1'b0, 6'd5, 32'h0000_2000, 32'h0000_0077, 9'd40, 0, 1'b0, 0, 0, 0};
        cur = v;
        d0 = n_done;
        bus.cmd_wb = 1'b0; bus.cmd_index = v.idx; bus.cmd_mem_addr = v.addr; bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
        bus.mem_rreq_ready = 1'b1;
        cycle();
        bus.mem_rreq_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata = v.base + 32'(k);
            if (k < 4) push_wr(v.exp_word0 + AW'(k), v.base + 32'(k), cyc + 1);
            cycle();
        end
        bus.mem_rdata = v.base + 32'd5;
        rst_n = 1'b0;
        #1;
        check("reset_midline_outputs", out_vec(), reset_out);
        bus.mem_rdata_valid = 1'b0;
        cycle();
        check("reset_writes_before", wr_q.size(), 0);
        check("reset_no_done", n_done - d0, 0);
        rst_n = 1'b1;
        cycle();
        check("post_reset_idle", out_vec(), reset_out);
        $display("reset mid-refill: line 5 abandoned at cycle %0d", cyc);
        v = '{1'b0, 6'd3, 32'h0000_1000, 32'h0000_00C0, 9'd24, 0, 1'b0, 0, 0, 0};
        run_vec(6, v);
        v = '{1'b1, 6'd3, 32'h0000_1000, 32'h0000_00C0, 9'd24, 0, 1'b0, 0, 2, 1};
        run_vec(7, v);

        // cmd_valid held high across two writebacks.
        cur = '{1'b1, 6'd63, 32'h0000_5000, 32'h0000_0100, 9'd504, 0, 1'b0, 0, 0, 0};
        d0 = n_done; acc0 = n_accept; first_acc = -1; second_acc = -1;
        bus.cmd_wb = 1'b1; bus.cmd_index = cur.idx; bus.cmd_mem_addr = cur.addr; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 60 && (n_done - d0) < 2; i++) begin
            cycle();
            if (n_accept - acc0 == 1 && first_acc < 0) first_acc = cyc - 1;
            if (n_accept - acc0 == 2 && second_acc < 0) begin
                second_acc = cyc - 1;
                bus.cmd_valid = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        check("held_accepts", n_accept - acc0, 2);
        check("held_done_count", n_done - d0, 2);
        check("held_accept_spacing", second_acc - first_acc, 11);
        check("held_wb_queue_drained", wb_q.size(), 0);
        $display("held cmd_valid: accepts at cycles %0d and %0d", first_acc, second_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
